// File: rtl/dmem_access.sv
// Data-memory access unit for the MEM stage: issues one load or store per
// request, holds the pipeline while the memory is busy, and aligns load data.
module dmem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_mbe,
  input  logic        dmem_resp,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic [31:0] mdr_out,
  output logic [3:0]  rmask,
  output logic [3:0]  wmask,
  output logic        misaligned
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        read_q, write_q;
  logic [31:0] address_q, wdata_q, mdr_q;
  logic [3:0]  mbe_q, rmask_q, wmask_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;

  logic        is_half, is_word, align_err, accept, complete;
  logic [3:0]  req_mbe;
  logic [31:0] req_wdata, lane_word, load_data;

  // funct3[1:0]: 00 byte, 01 half, 1x word; funct3[2] selects zero-extension.
  assign is_half   = (funct3[1:0] == 2'b01);
  assign is_word   = funct3[1];
  assign align_err = (is_word & (addr[1:0] != 2'b00)) | (is_half & addr[0]);

  // A simultaneous read and write is not a legal access and is trapped.
  assign misaligned = req_valid &
                      ((req_read & req_write) | ((req_read | req_write) & align_err));

  assign accept   = (state_q == IDLE) & req_valid & (req_read ^ req_write) & ~misaligned;
  assign complete = (state_q == BUSY) & dmem_resp;
  assign stall    = (state_q == BUSY) | accept;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    req_mbe   = 4'b1111;
    req_wdata = wdata;
    case (funct3[1:0])
      2'b00: begin
        req_mbe   = 4'b0001 << addr[1:0];
        req_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        req_mbe   = 4'b0011 << {addr[1], 1'b0};
        req_wdata = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction uses the latched offset so addr may move while BUSY.
  assign lane_word = dmem_rdata >> {off_q, 3'b000};

  always_comb begin
    load_data = dmem_rdata;
    case (funct3_q)
      3'b000:  load_data = {{24{lane_word[7]}}, lane_word[7:0]};
      3'b001:  load_data = {{16{lane_word[15]}}, lane_word[15:0]};
      3'b100:  load_data = {24'h0, lane_word[7:0]};
      3'b101:  load_data = {16'h0, lane_word[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = BUSY;
      BUSY:    if (dmem_resp) state_d = DONE;
      DONE:                   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      address_q <= 32'h0;
      wdata_q   <= 32'h0;
      mbe_q     <= 4'h0;
      funct3_q  <= 3'h0;
      off_q     <= 2'h0;
      mdr_q     <= 32'h0;
      rmask_q   <= 4'h0;
      wmask_q   <= 4'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        read_q    <= req_read;
        write_q   <= req_write;
        address_q <= {addr[31:2], 2'b00};
        wdata_q   <= req_wdata;
        mbe_q     <= req_mbe;
        funct3_q  <= funct3;
        off_q     <= addr[1:0];
      end
      if (complete) begin
        read_q  <= 1'b0;
        write_q <= 1'b0;
        if (read_q) begin
          mdr_q   <= load_data;
          rmask_q <= mbe_q;
        end
        if (write_q) wmask_q <= mbe_q;
      end
    end
  end

  assign dmem_read    = read_q;
  assign dmem_write   = write_q;
  assign dmem_address = address_q;
  assign dmem_wdata   = wdata_q;
  assign dmem_mbe     = mbe_q;
  assign mdr_out      = mdr_q;
  assign rmask        = rmask_q;
  assign wmask        = wmask_q;

endmodule

// File: tb/tb_dmem_access.sv
// Scoreboard bench for dmem_access: a driver queues expected accesses, a
// monitor doubling as the memory model checks strobes, lanes and load data.
module tb_dmem_access;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_read = 1'b0, req_write = 1'b0;
  logic [2:0]  funct3 = 3'h0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic        dmem_read, dmem_write;
  logic [31:0] dmem_address, dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic        dmem_resp = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;
  logic        stall;
  logic [31:0] mdr_out;
  logic [3:0]  rmask, wmask;
  logic        misaligned;

  dmem_access dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_read(req_read),
    .req_write(req_write), .funct3(funct3), .addr(addr), .wdata(wdata),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
    .dmem_wdata(dmem_wdata), .dmem_mbe(dmem_mbe), .dmem_resp(dmem_resp),
    .dmem_rdata(dmem_rdata), .stall(stall), .mdr_out(mdr_out), .rmask(rmask),
    .wmask(wmask), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ld;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] w;
    logic [31:0] rd;
    int          dly;
  } txn_t;

  txn_t        exp_q[$];
  int          total = 0, bad = 0;
  int          issued = 0, done_cnt = 0;
  bit          mon_en = 1'b0;
  logic [31:0] m_mdr = 32'h0;
  logic [3:0]  m_rmask = 4'h0, m_wmask = 4'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: access size in bytes, lane enables, replicated data, load value.
  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [3:0] lanes(input logic [2:0] f3, input logic [31:0] a);
    int n = size_of(f3);
    int first = int'(a % 4) / n * n;
    int m = 0;
    for (int i = 0; i < n; i++) m += 1 << (first + i);
    return 4'(m);
  endfunction

  function automatic logic [31:0] store_word(input logic [2:0] f3, input logic [31:0] w);
    if (size_of(f3) == 1) return (w & 32'hFF) * 32'h0101_0101;
    if (size_of(f3) == 2) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    int n = size_of(f3);
    longint v;
    if (n == 4) return rd;
    v = longint'((rd >> (8 * (int'(a % 4) / n * n))) & ((32'h1 << (8 * n)) - 1));
    if (!f3[2] && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return 32'(v);
  endfunction

  // Monitor + memory model: answers each strobe after the queued delay.
  initial begin
    txn_t e;
    logic [31:0] ea;
    forever begin
      @(negedge clk); #2;
      if (!mon_en) continue;
      dmem_resp = 1'b0;
      if (dmem_read === 1'b1 || dmem_write === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {dmem_read, dmem_write}, 32'h0);
        end else begin
          e  = exp_q.pop_front();
          ea = e.a & 32'hFFFF_FFFC;
          for (int k = 0; k <= e.dly; k++) begin
            if (k > 0) begin @(negedge clk); #2; end
            check("strobe_kind", {dmem_read, dmem_write}, e.ld ? 32'h2 : 32'h1);
            check("busy_stall", stall, 32'h1);
            check("address", dmem_address, ea);
            if (!e.ld) begin
              check("store_mbe", dmem_mbe, lanes(e.f3, e.a));
              check("store_wdata", dmem_wdata, store_word(e.f3, e.w));
            end
          end
          dmem_rdata = e.rd;
          dmem_resp  = 1'b1;
          @(negedge clk); #2;
          // DONE cycle: a stray response here must be ignored.
          dmem_resp  = 1'($urandom_range(0, 1));
          dmem_rdata = $urandom;
          if (e.ld) begin
            m_mdr   = load_value(e.f3, e.a, e.rd);
            m_rmask = lanes(e.f3, e.a);
          end else begin
            m_wmask = lanes(e.f3, e.a);
          end
          check("done_strobes", {dmem_read, dmem_write}, 32'h0);
          check("done_stall", stall, 32'h0);
          check("mdr_out", mdr_out, m_mdr);
          check("rmask", rmask, m_rmask);
          check("wmask", wmask, m_wmask);
          done_cnt++;
        end
      end
    end
  end

  task automatic issue(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] w, input logic [31:0] rdat, input int dly);
    bit   mis, acc;
    int   n;
    txn_t t;
    @(negedge clk); #3;
    req_valid = 1'b1; req_read = rd; req_write = wr; funct3 = f3; addr = a; wdata = w;
    #1;
    mis = (rd && wr) || ((rd || wr) && (a % size_of(f3) != 0));
    acc = (rd != wr) && !mis;
    check("misaligned", misaligned, mis);
    check("stall_req", stall, acc);
    if (acc) begin
      t = '{ld: rd, f3: f3, a: a, w: w, rd: rdat, dly: dly};
      exp_q.push_back(t);
      issued++;
      n = 0;
      do begin
        @(negedge clk); #3;
        req_valid = 1'($urandom); req_read = 1'($urandom); req_write = 1'($urandom);
        funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
        n++;
      end while (done_cnt < issued && n < 40);
      if (done_cnt < issued) begin
        check("completion_timeout", 32'(done_cnt), 32'(issued));
        done_cnt = issued;
      end else begin
        // Hold the same request through DONE: it must not be re-accepted.
        req_valid = 1'b1; req_read = rd; req_write = wr; funct3 = f3; addr = a; wdata = w;
        #1;
        check("stall_in_done", stall, 32'h0);
      end
    end
    @(negedge clk); #3;
    req_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          rd, wr;
    int          r;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [2:0]  load_codes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    repeat (3) @(negedge clk);
    #3 rst = 1'b0;
    #1;
    check("rst_read", dmem_read, 32'h0);
    check("rst_write", dmem_write, 32'h0);
    check("rst_address", dmem_address, 32'h0);
    check("rst_wdata", dmem_wdata, 32'h0);
    check("rst_mbe", dmem_mbe, 32'h0);
    check("rst_mdr", mdr_out, 32'h0);
    check("rst_masks", {rmask, wmask}, 32'h0);
    check("rst_stall", stall, 32'h0);
    mon_en = 1'b1;

    // Misaligned-looking request without req_valid is not a trap.
    @(negedge clk); #3;
    req_valid = 1'b0; req_read = 1'b1; funct3 = 3'b010; addr = 32'h1; #1;
    check("invalid_not_mis", misaligned, 32'h0);

    issue(1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 1);
    check("lb_mdr", mdr_out, 32'hFFFF_FF80);
    check("lb_rmask", rmask, 32'h8);
    issue(0, 1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 0);
    check("sh_wmask", wmask, 32'hC);
    issue(1, 0, 3'b010, 32'h0000_3001, 32'h0, 32'h0, 0);
    check("lw_mis_mdr_hold", mdr_out, 32'hFFFF_FF80);
    issue(1, 0, 3'b101, 32'h0000_4002, 32'h0, 32'hA5A5_0000, 0);
    check("lhu_mdr", mdr_out, 32'h0000_A5A5);
    issue(1, 1, 3'b010, 32'h0000_5000, 32'h0, 32'h0, 0);

    for (int i = 0; i < 300; i++) begin
      r  = $urandom_range(0, 11);
      rd = (r < 5) || (r == 10);
      wr = (r >= 5 && r < 10) || (r == 10);
      if (rd && !wr)      f3 = load_codes[$urandom_range(0, 4)];
      else if (wr && !rd) f3 = 3'($urandom_range(0, 2));
      else                f3 = 3'($urandom);
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[0] = 1'b0;
      if ($urandom_range(0, 1) == 1) a[1] = 1'b0;
      issue(rd, wr, f3, a, $urandom, $urandom, $urandom_range(0, 3));
    end
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    // Reset while BUSY, with responses during and after the reset cycle.
    mon_en = 1'b0;
    @(negedge clk); #3;
    dmem_resp = 1'b0;
    req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0; funct3 = 3'b010; addr = 32'h0000_7000;
    @(negedge clk); #3;
    req_valid = 1'b0;
    check("rb_busy_read", dmem_read, 32'h1);
    rst = 1'b1; dmem_resp = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk); #3;
    rst = 1'b0;
    check("rb_strobes", {dmem_read, dmem_write}, 32'h0);
    check("rb_mdr", mdr_out, 32'h0);
    @(negedge clk); #3;
    dmem_resp = 1'b0;
    check("rb_after_resp_strobes", {dmem_read, dmem_write}, 32'h0);
    check("rb_after_resp_mdr", mdr_out, 32'h0);
    check("rb_after_resp_masks", {rmask, wmask}, 32'h0);
    check("rb_idle_stall", stall, 32'h0);
    req_valid = 1'b1; #1;
    check("rb_idle_accepts", stall, 32'h1);
    req_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
